// File: rtl/sat_bin_pkg.sv
// Shared widths, state-word layouts and FSM encoding for the bin endpoint.
package sat_bin_pkg;

    localparam int NUM_CLAUSES_A_BIN = 8;
    localparam int NUM_VARS_A_BIN    = 8;
    localparam int NUM_LVLS_A_BIN    = 8;
    localparam int WIDTH_BIN_ID      = 10;
    localparam int WIDTH_LVL         = 16;
    localparam int WIDTH_VAR_STATES  = 19;
    localparam int WIDTH_LVL_STATES  = 11;

    // 2 + 1 + 16 = 19 bits: assignment value, implied flag, decision level
    typedef struct packed {
        logic [1:0]           value;
        logic                 implied;
        logic [WIDTH_LVL-1:0] level;
    } var_state_t;

    // 10 + 1 = 11 bits: bin that made the decision, backtrack pending
    typedef struct packed {
        logic [WIDTH_BIN_ID-1:0] dcd_bin;
        logic                    has_bkt;
    } lvl_state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } core_state_e;

endpackage

// File: rtl/core_state_regs.sv
// Var/lvl state register file. The manager and engine ports are never active
// in the same FSM state; the engine still wins if both hit one slot.
module core_state_regs
    import sat_bin_pkg::*;
#(
    parameter int NV = NUM_VARS_A_BIN,
    parameter int NL = NUM_LVLS_A_BIN
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NV-1:0]                 mgr_vs_we,
    input  logic [WIDTH_VAR_STATES*NV-1:0] mgr_vs,
    input  logic [NV-1:0]                 eng_vs_we,
    input  logic [WIDTH_VAR_STATES*NV-1:0] eng_vs,
    input  logic [NL-1:0]                 mgr_ls_we,
    input  logic [WIDTH_LVL_STATES*NL-1:0] mgr_ls,
    input  logic [NL-1:0]                 eng_ls_we,
    input  logic [WIDTH_LVL_STATES*NL-1:0] eng_ls,
    output logic [WIDTH_VAR_STATES*NV-1:0] var_states,
    output logic [WIDTH_LVL_STATES*NL-1:0] lvl_states
);

    var_state_t [NV-1:0] vs_q;
    lvl_state_t [NL-1:0] ls_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_q <= '0;
        end else begin
            for (int i = 0; i < NV; i++) begin
                if (eng_vs_we[i])
                    vs_q[i] <= eng_vs[i*WIDTH_VAR_STATES +: WIDTH_VAR_STATES];
                else if (mgr_vs_we[i])
                    vs_q[i] <= mgr_vs[i*WIDTH_VAR_STATES +: WIDTH_VAR_STATES];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ls_q <= '0;
        end else begin
            for (int i = 0; i < NL; i++) begin
                if (eng_ls_we[i])
                    ls_q[i] <= eng_ls[i*WIDTH_LVL_STATES +: WIDTH_LVL_STATES];
                else if (mgr_ls_we[i])
                    ls_q[i] <= mgr_ls[i*WIDTH_LVL_STATES +: WIDTH_LVL_STATES];
            end
        end
    end

    assign var_states = vs_q;
    assign lvl_states = ls_q;

endmodule

// File: rtl/core_bin_port.sv
// Engine-side endpoint of the bin load/update protocol: clause rows, state
// registers, start/done handshake with the engine and manager read-back.
//
//   state   | meaning
//   IDLE    | manager owns the bin: writes accepted, waiting for start
//   RUN     | engine owns the bin: engine state writes, manager writes flagged
//   DONE    | one-cycle done pulse to the manager, results held
module core_bin_port
    import sat_bin_pkg::*;
#(
    parameter int NC = NUM_CLAUSES_A_BIN,
    parameter int NV = NUM_VARS_A_BIN,
    parameter int NL = NUM_LVLS_A_BIN
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start_core_i,
    output logic                           done_core_o,
    input  logic [WIDTH_BIN_ID-1:0]        cur_bin_num_i,
    input  logic [WIDTH_LVL-1:0]           cur_lvl_i,
    output logic                           local_sat_o,
    output logic                           local_unsat_o,
    output logic [WIDTH_LVL-1:0]           cur_lvl_o,
    output logic [WIDTH_LVL-1:0]           bkt_lvl_o,
    output logic [WIDTH_BIN_ID-1:0]        bkt_bin_o,
    input  logic [NC-1:0]                  wr_carray_i,
    input  logic [NC-1:0]                  rd_carray_i,
    input  logic [2*NV-1:0]                clause_i,
    output logic [2*NV-1:0]                clause_o,
    input  logic [NV-1:0]                  wr_var_states_i,
    input  logic [WIDTH_VAR_STATES*NV-1:0] var_states_i,
    output logic [WIDTH_VAR_STATES*NV-1:0] var_states_o,
    input  logic [NL-1:0]                  wr_lvl_states_i,
    input  logic [WIDTH_LVL_STATES*NL-1:0] lvl_states_i,
    output logic [WIDTH_LVL_STATES*NL-1:0] lvl_states_o,
    input  logic                           base_lvl_en_i,
    input  logic [WIDTH_LVL-1:0]           base_lvl_i,
    output logic [WIDTH_LVL-1:0]           base_lvl_o,
    output logic                           eng_start_o,
    input  logic                           eng_done_i,
    input  logic                           eng_sat_i,
    input  logic                           eng_unsat_i,
    input  logic [WIDTH_LVL-1:0]           eng_cur_lvl_i,
    input  logic [WIDTH_LVL-1:0]           eng_bkt_lvl_i,
    input  logic [WIDTH_BIN_ID-1:0]        eng_bkt_bin_i,
    input  logic [NV-1:0]                  eng_vs_we_i,
    input  logic [WIDTH_VAR_STATES*NV-1:0] eng_vs_i,
    input  logic [NL-1:0]                  eng_ls_we_i,
    input  logic [WIDTH_LVL_STATES*NL-1:0] eng_ls_i,
    output logic [NC*2*NV-1:0]             carray_o,
    output logic                           err_o
);

    localparam int CW = 2 * NV;

    core_state_e state_q, state_d;

    logic [CW-1:0]           carray_q [NC];
    logic [CW-1:0]           rd_row;
    logic [CW-1:0]           clause_q;
    logic                    eng_start_q;
    logic                    sat_q, unsat_q, err_q;
    logic [WIDTH_LVL-1:0]    cur_lvl_q, bkt_lvl_q, base_lvl_q;
    logic [WIDTH_BIN_ID-1:0] bkt_bin_q;

    logic is_idle, is_run, mgr_wr_any, start_ok, done_ok;

    assign is_idle    = (state_q == ST_IDLE);
    assign is_run     = (state_q == ST_RUN);
    assign mgr_wr_any = (|wr_carray_i) | (|wr_var_states_i) | (|wr_lvl_states_i)
                      | base_lvl_en_i;
    assign start_ok   = is_idle & start_core_i;
    assign done_ok    = is_run & eng_done_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_core_i) state_d = ST_RUN;
            ST_RUN:  if (eng_done_i)   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NC; i++) carray_q[i] <= '0;
        end else if (is_idle) begin
            for (int i = 0; i < NC; i++)
                if (wr_carray_i[i]) carray_q[i] <= clause_i;
        end
    end

    // Lowest set select bit wins.
    always_comb begin
        rd_row = '0;
        for (int i = NC - 1; i >= 0; i--)
            if (rd_carray_i[i]) rd_row = carray_q[i];
    end

    // bkt_bin/cur_lvl are preloaded with the manager's bin and level at start
    // so they carry meaningful values until the engine reports its own.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            eng_start_q <= 1'b0;
            sat_q       <= 1'b0;
            unsat_q     <= 1'b0;
            err_q       <= 1'b0;
            cur_lvl_q   <= '0;
            bkt_lvl_q   <= '0;
            bkt_bin_q   <= '0;
            base_lvl_q  <= '0;
            clause_q    <= '0;
        end else begin
            eng_start_q <= start_ok;
            if (start_ok) begin
                sat_q     <= 1'b0;
                unsat_q   <= 1'b0;
                cur_lvl_q <= cur_lvl_i;
                bkt_bin_q <= cur_bin_num_i;
            end else if (done_ok) begin
                sat_q     <= eng_sat_i & ~eng_unsat_i;
                unsat_q   <= eng_unsat_i;
                cur_lvl_q <= eng_cur_lvl_i;
                bkt_lvl_q <= eng_bkt_lvl_i;
                bkt_bin_q <= eng_bkt_bin_i;
            end
            if (is_run & (mgr_wr_any | start_core_i | (eng_done_i & eng_sat_i & eng_unsat_i)))
                err_q <= 1'b1;
            if (is_idle & base_lvl_en_i)
                base_lvl_q <= base_lvl_i;
            if (|rd_carray_i)
                clause_q <= rd_row;
        end
    end

    core_state_regs #(
        .NV(NV),
        .NL(NL)
    ) u_state_regs (
        .clk        (clk),
        .rst        (rst),
        .mgr_vs_we  (wr_var_states_i & {NV{is_idle}}),
        .mgr_vs     (var_states_i),
        .eng_vs_we  (eng_vs_we_i & {NV{is_run}}),
        .eng_vs     (eng_vs_i),
        .mgr_ls_we  (wr_lvl_states_i & {NL{is_idle}}),
        .mgr_ls     (lvl_states_i),
        .eng_ls_we  (eng_ls_we_i & {NL{is_run}}),
        .eng_ls     (eng_ls_i),
        .var_states (var_states_o),
        .lvl_states (lvl_states_o)
    );

    for (genvar g = 0; g < NC; g++) begin : g_carray
        assign carray_o[g*CW +: CW] = carray_q[g];
    end

    assign done_core_o   = (state_q == ST_DONE);
    assign eng_start_o   = eng_start_q;
    assign local_sat_o   = sat_q;
    assign local_unsat_o = unsat_q;
    assign cur_lvl_o     = cur_lvl_q;
    assign bkt_lvl_o     = bkt_lvl_q;
    assign bkt_bin_o     = bkt_bin_q;
    assign base_lvl_o    = base_lvl_q;
    assign clause_o      = clause_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_core_bin_port.sv
// Directed bench for core_bin_port: load/read-back table plus hand-written
// handshake, error and reset sequences.
module tb_core_bin_port;
    import sat_bin_pkg::*;

    localparam int NC  = 8;
    localparam int NV  = 8;
    localparam int NL  = 8;
    localparam int CW  = 16;
    localparam int WVS = 19;
    localparam int WLS = 11;

    logic                    clk, rst;
    logic                    start_core_i, done_core_o;
    logic [WIDTH_BIN_ID-1:0] cur_bin_num_i, bkt_bin_o, eng_bkt_bin_i;
    logic [WIDTH_LVL-1:0]    cur_lvl_i, cur_lvl_o, bkt_lvl_o, base_lvl_i, base_lvl_o;
    logic [WIDTH_LVL-1:0]    eng_cur_lvl_i, eng_bkt_lvl_i;
    logic                    local_sat_o, local_unsat_o;
    logic [NC-1:0]           wr_carray_i, rd_carray_i;
    logic [CW-1:0]           clause_i, clause_o;
    logic [NV-1:0]           wr_var_states_i, eng_vs_we_i;
    logic [WVS*NV-1:0]       var_states_i, var_states_o, eng_vs_i;
    logic [NL-1:0]           wr_lvl_states_i, eng_ls_we_i;
    logic [WLS*NL-1:0]       lvl_states_i, lvl_states_o, eng_ls_i;
    logic                    base_lvl_en_i, eng_start_o;
    logic                    eng_done_i, eng_sat_i, eng_unsat_i;
    logic [NC*CW-1:0]        carray_o;
    logic                    err_o;

    core_bin_port dut (
        .clk(clk), .rst(rst),
        .start_core_i(start_core_i), .done_core_o(done_core_o),
        .cur_bin_num_i(cur_bin_num_i), .cur_lvl_i(cur_lvl_i),
        .local_sat_o(local_sat_o), .local_unsat_o(local_unsat_o),
        .cur_lvl_o(cur_lvl_o), .bkt_lvl_o(bkt_lvl_o), .bkt_bin_o(bkt_bin_o),
        .wr_carray_i(wr_carray_i), .rd_carray_i(rd_carray_i),
        .clause_i(clause_i), .clause_o(clause_o),
        .wr_var_states_i(wr_var_states_i), .var_states_i(var_states_i),
        .var_states_o(var_states_o),
        .wr_lvl_states_i(wr_lvl_states_i), .lvl_states_i(lvl_states_i),
        .lvl_states_o(lvl_states_o),
        .base_lvl_en_i(base_lvl_en_i), .base_lvl_i(base_lvl_i), .base_lvl_o(base_lvl_o),
        .eng_start_o(eng_start_o), .eng_done_i(eng_done_i),
        .eng_sat_i(eng_sat_i), .eng_unsat_i(eng_unsat_i),
        .eng_cur_lvl_i(eng_cur_lvl_i), .eng_bkt_lvl_i(eng_bkt_lvl_i),
        .eng_bkt_bin_i(eng_bkt_bin_i),
        .eng_vs_we_i(eng_vs_we_i), .eng_vs_i(eng_vs_i),
        .eng_ls_we_i(eng_ls_we_i), .eng_ls_i(eng_ls_i),
        .carray_o(carray_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [NC-1:0] rd;
        logic [CW-1:0] exp;
    } rd_vec_t;

    rd_vec_t rv [7];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        start_core_i = 0; cur_bin_num_i = '0; cur_lvl_i = '0;
        wr_carray_i = '0; rd_carray_i = '0; clause_i = '0;
        wr_var_states_i = '0; var_states_i = '0;
        wr_lvl_states_i = '0; lvl_states_i = '0;
        base_lvl_en_i = 0; base_lvl_i = '0;
        eng_done_i = 0; eng_sat_i = 0; eng_unsat_i = 0;
        eng_cur_lvl_i = '0; eng_bkt_lvl_i = '0; eng_bkt_bin_i = '0;
        eng_vs_we_i = '0; eng_vs_i = '0; eng_ls_we_i = '0; eng_ls_i = '0;

        rv[0] = '{8'h20, 16'h0020};
        rv[1] = '{8'h01, 16'h0001};
        rv[2] = '{8'h30, 16'h0010};
        rv[3] = '{8'h80, 16'h0080};
        rv[4] = '{8'h00, 16'h0080};
        rv[5] = '{8'hFF, 16'h0001};
        rv[6] = '{8'h0C, 16'h0004};

        step(); step();
        check("rst_done",    160'(done_core_o), 160'(1'b0));
        check("rst_start",   160'(eng_start_o), 160'(1'b0));
        check("rst_err",     160'(err_o), 160'(1'b0));
        check("rst_result",  160'({local_sat_o, local_unsat_o, cur_lvl_o, bkt_lvl_o, bkt_bin_o}), 160'(0));
        check("rst_carray",  160'(carray_o), 160'(0));
        check("rst_vs",      160'(var_states_o), 160'(0));
        check("rst_ls_base", 160'({lvl_states_o, base_lvl_o, clause_o}), 160'(0));
        rst = 1'b1;
        step();

        // load rows 0..7 with a walking one
        for (int i = 0; i < NC; i++) begin
            wr_carray_i = NC'(1) << i;
            clause_i    = CW'(1) << i;
            step();
        end
        wr_carray_i = '0;
        check("carray_row5", 160'(carray_o[5*CW +: CW]), 160'(16'h0020));

        for (int i = 0; i < 7; i++) begin
            rd_carray_i = rv[i].rd;
            step();
            check($sformatf("rd_vec%0d", i), 160'(clause_o), 160'(rv[i].exp));
        end
        rd_carray_i = '0;

        // multi-hot write
        wr_carray_i = 8'h0C; clause_i = 16'hABCD;
        step();
        wr_carray_i = '0;
        check("mh_rows", 160'(carray_o[1*CW +: 4*CW]), 160'(64'h0010_ABCD_ABCD_0002));

        // manager state writes
        wr_var_states_i = 8'h02; var_states_i = '0; var_states_i[1*WVS +: WVS] = 19'h2BCDE;
        wr_lvl_states_i = 8'h80; lvl_states_i = '0; lvl_states_i[7*WLS +: WLS] = 11'h5A5;
        base_lvl_en_i = 1; base_lvl_i = 16'h00C3;
        step();
        wr_var_states_i = '0; wr_lvl_states_i = '0; base_lvl_en_i = 0;
        check("mgr_vs", 160'(var_states_o[0 +: 2*WVS]), 160'({19'h2BCDE, 19'h0}));
        check("mgr_ls", 160'(lvl_states_o), 160'({11'h5A5, 77'h0}));
        check("mgr_base", 160'(base_lvl_o), 160'(16'h00C3));

        // handshake: engine done two cycles after eng_start_o
        cur_bin_num_i = 10'd3; cur_lvl_i = 16'h0007; start_core_i = 1;
        step();
        start_core_i = 0;
        check("hs_eng_start", 160'({eng_start_o, done_core_o}), 160'(2'b10));
        eng_vs_we_i = 8'h01; eng_vs_i = '0; eng_vs_i[18:0] = 19'h12345;
        step();
        eng_vs_we_i = '0;
        check("hs_start_pulse", 160'(eng_start_o), 160'(1'b0));
        step();
        eng_done_i = 1; eng_sat_i = 1; eng_unsat_i = 0;
        eng_bkt_lvl_i = 16'd4; eng_bkt_bin_i = 10'd5; eng_cur_lvl_i = 16'd9;
        check("hs_no_early_done", 160'(done_core_o), 160'(1'b0));
        step();
        eng_done_i = 0; eng_sat_i = 0;
        check("hs_done", 160'(done_core_o), 160'(1'b1));
        check("hs_result", 160'({local_sat_o, local_unsat_o, bkt_lvl_o, bkt_bin_o, cur_lvl_o}),
              160'({1'b1, 1'b0, 16'd4, 10'd5, 16'd9}));
        check("hs_eng_vs", 160'(var_states_o[0 +: 2*WVS]), 160'({19'h2BCDE, 19'h12345}));
        check("hs_err", 160'(err_o), 160'(1'b0));
        step();
        check("hs_done_1cyc", 160'({done_core_o, local_sat_o}), 160'(2'b01));

        // minimum latency: engine done with eng_start_o
        start_core_i = 1;
        step();
        start_core_i = 0;
        check("min_sat_cleared", 160'(local_sat_o), 160'(1'b0));
        eng_done_i = 1; eng_unsat_i = 1; eng_bkt_lvl_i = 16'd2;
        step();
        eng_done_i = 0; eng_unsat_i = 0;
        check("min_done", 160'({done_core_o, local_sat_o, local_unsat_o, bkt_lvl_o}),
              160'({1'b1, 1'b0, 1'b1, 16'd2}));
        step();

        // sat and unsat together
        start_core_i = 1;
        step();
        start_core_i = 0;
        eng_done_i = 1; eng_sat_i = 1; eng_unsat_i = 1;
        step();
        eng_done_i = 0; eng_sat_i = 0; eng_unsat_i = 0;
        check("both_result", 160'({local_sat_o, local_unsat_o, err_o}), 160'(3'b011));
        step();

        rst = 1'b0;
        step();
        rst = 1'b1;
        check("err_cleared", 160'(err_o), 160'(1'b0));

        // manager write during RUN is dropped
        wr_carray_i = 8'h01; clause_i = 16'h1111;
        step();
        start_core_i = 1; wr_carray_i = '0;
        step();
        start_core_i = 0;
        wr_carray_i = 8'h01; clause_i = 16'hFFFF;
        step();
        wr_carray_i = '0;
        check("run_wr_drop", 160'({carray_o[CW-1:0], err_o}), 160'({16'h1111, 1'b1}));
        start_core_i = 1;
        step();
        start_core_i = 0;
        check("run_start_ign", 160'({eng_start_o, done_core_o}), 160'(2'b00));

        // asynchronous reset mid-RUN
        #2 rst = 1'b0;
        #1;
        check("mr_ctrl", 160'({done_core_o, eng_start_o, err_o, local_sat_o, local_unsat_o}), 160'(0));
        check("mr_carray", 160'(carray_o), 160'(0));
        check("mr_regs", 160'({cur_lvl_o, bkt_lvl_o, bkt_bin_o, base_lvl_o, clause_o}), 160'(0));
        rst = 1'b1;
        eng_done_i = 1; eng_sat_i = 1;
        step();
        eng_done_i = 0; eng_sat_i = 0;
        begin
            logic seen;
            seen = 1'b0;
            for (int c = 0; c < 4; c++) begin
                if (done_core_o) seen = 1'b1;
                step();
            end
            check("mr_no_done", 160'({seen, local_sat_o}), 160'(2'b00));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
